// File: rtl/uart_frame_checker_if.sv
// uart_frame_checker_if: bundles the frame-checker handshake signals.
//   master : shift stage / consumer side. It drives rxin, checkstop, dout1,
//            pbit and errclr, and receives the results.
//   slave  : checker side. It receives the inputs above and drives rxdataout,
//            stopbiterror, parityerror, done, busy and errcount.
interface uart_frame_checker_if #(
    parameter int DATA_W = 8
);
    logic              rxin;
    logic              checkstop;
    logic [DATA_W-1:0] dout1;
    logic              pbit;
    logic              errclr;
    logic [DATA_W-1:0] rxdataout;
    logic              stopbiterror;
    logic              parityerror;
    logic              done;
    logic              busy;
    logic [7:0]        errcount;

    modport master (
        output rxin, checkstop, dout1, pbit, errclr,
        input  rxdataout, stopbiterror, parityerror, done, busy, errcount
    );

    modport slave (
        input  rxin, checkstop, dout1, pbit, errclr,
        output rxdataout, stopbiterror, parityerror, done, busy, errcount
    );
endinterface

// File: rtl/uart_frame_checker.sv
// uart_frame_checker: checks the stop bit(s) and the optional parity bit of
// a received UART frame. It then reports the checked word, the error flags
// and a saturating count of errored frames.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave modport of uart_frame_checker_if
//           in : rxin, checkstop, dout1, pbit, errclr
//           out: rxdataout, stopbiterror, parityerror, done, busy, errcount
module uart_frame_checker #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_frame_checker_if.slave  bus
);
    localparam int              CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic             IDX_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        STOP,
        REPORT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bitcnt;
    logic              stopidx;
    logic [DATA_W-1:0] data_q;
    logic              pbit_q;

    logic perr;
    logic sample_fail;
    logic last_wrap;

    always_comb begin
        perr        = 1'b0;
        sample_fail = 1'b0;
        last_wrap   = 1'b0;
        if (PARITY_EN != 0)
            perr = ^data_q ^ pbit_q ^ 1'(PARITY_ODD);
        // A low stop-bit sample aborts the frame at once. A clean final wrap
        // ends it normally.
        if (state == STOP) begin
            sample_fail = (bitcnt == CNT_MID) && !bus.rxin;
            last_wrap   = (bitcnt == CNT_LAST) && (stopidx == IDX_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bitcnt           <= '0;
            stopidx          <= 1'b0;
            data_q           <= '0;
            pbit_q           <= 1'b0;
            bus.rxdataout    <= '0;
            bus.stopbiterror <= 1'b0;
            bus.parityerror  <= 1'b0;
            bus.done         <= 1'b0;
            bus.busy         <= 1'b0;
            bus.errcount     <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.checkstop) begin
                        data_q   <= bus.dout1;
                        pbit_q   <= bus.pbit;
                        bitcnt   <= '0;
                        stopidx  <= 1'b0;
                        state    <= STOP;
                        bus.busy <= 1'b1;
                    end
                end
                STOP: begin
                    if (bitcnt == CNT_LAST) begin
                        bitcnt  <= '0;
                        stopidx <= stopidx + 1'b1;
                    end else begin
                        bitcnt <= bitcnt + CNT_W'(1);
                    end
                    if (sample_fail || last_wrap) begin
                        state            <= REPORT;
                        bus.stopbiterror <= sample_fail;
                        bus.parityerror  <= perr;
                        bus.rxdataout    <= (sample_fail || perr) ? '0 : data_q;
                        bus.done         <= 1'b1;
                    end
                end
                REPORT: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase

            // The count advances in the cycle where done is high. This lets a
            // same-cycle errclr win.
            if (bus.errclr)
                bus.errcount <= '0;
            else if (state == REPORT && (bus.stopbiterror || bus.parityerror)
                     && bus.errcount != 8'hFF)
                bus.errcount <= bus.errcount + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_frame_checker.sv
module tb_uart_frame_checker;
    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ecnt[2];

    typedef struct {
        logic [7:0]  data;
        logic        serr;
        logic        perr;
        int unsigned cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_checker_if #(.DATA_W(8)) ifa ();
    uart_frame_checker_if #(.DATA_W(8)) ifb ();

    uart_frame_checker #(.DATA_W(8), .OVERSAMPLE(16), .STOP_BITS(1),
                         .PARITY_EN(0), .PARITY_ODD(0))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));

    uart_frame_checker #(.DATA_W(8), .OVERSAMPLE(16), .STOP_BITS(2),
                         .PARITY_EN(1), .PARITY_ODD(0))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int sel, input logic cs, input logic [7:0] d,
                         input logic p, input logic rx, input logic clr);
        if (sel == 0) begin
            ifa.checkstop = cs; ifa.dout1 = d; ifa.pbit = p; ifa.rxin = rx; ifa.errclr = clr;
        end else begin
            ifb.checkstop = cs; ifb.dout1 = d; ifb.pbit = p; ifb.rxin = rx; ifb.errclr = clr;
        end
    endtask

    // mode 0: line high; mode 1: line low (abort at first sample);
    // mode 2: line low except during each mid-bit sample cycle.
    task automatic frame(input int sel, input logic [7:0] d, input logic p,
                         input int mode, input bit poke, input bit clr_done,
                         input bit rst_mid);
        int unsigned a;
        int unsigned lat;
        logic ferr, perr, rx, cs;
        logic [7:0] dd;
        exp_t e;
        ferr = (mode == 1);
        perr = (sel == 1) ? (^d ^ p) : 1'b0;
        lat  = ferr ? 9 : 16 * ((sel == 1) ? 2 : 1);
        @(negedge clk);
        drive(sel, 1'b1, d, p, 1'b1, 1'b0);
        a = cyc + 1;
        e.data = (ferr || perr) ? 8'h00 : d;
        e.serr = ferr;
        e.perr = perr;
        e.cyc  = a + lat;
        if (!rst_mid) begin
            if (sel == 0) qa.push_back(e); else qb.push_back(e);
        end
        for (int k = 0; k <= int'(lat) + 1; k++) begin
            @(negedge clk);
            cs = poke && (k == 5 || k == int'(lat));
            dd = cs ? ~d : d;
            rx = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((k % 16) == 8);
            drive(sel, cs, dd, p, rx, clr_done && (k == int'(lat)));
            if (rst_mid && k == 6) reset = 1'b1;
            if (rst_mid && k == 7) begin
                chk("rst_mid_busy", ifa.busy, 0);
                chk("rst_mid_done", ifa.done, 0);
                chk("rst_mid_data", ifa.rxdataout, 0);
                chk("rst_mid_serr", ifa.stopbiterror, 0);
                chk("rst_mid_perr", ifa.parityerror, 0);
                chk("rst_mid_errcount", ifa.errcount, 0);
                reset = 1'b0;
                ecnt[0] = 0;
                ecnt[1] = 0;
                break;
            end
        end
        drive(sel, 1'b0, d, p, 1'b1, 1'b0);
        if (rst_mid) begin
            repeat (20) @(negedge clk);
        end else begin
            if (clr_done) ecnt[sel] = 0;
            else if ((ferr || perr) && ecnt[sel] < 255) ecnt[sel]++;
            chk(sel == 0 ? "a_busy_after" : "b_busy_after",
                sel == 0 ? ifa.busy : ifb.busy, 0);
            chk(sel == 0 ? "a_errcount" : "b_errcount",
                sel == 0 ? ifa.errcount : ifb.errcount, ecnt[sel]);
        end
    endtask

    // Scoreboard monitors: one per DUT, popping on each done pulse.
    always @(negedge clk) begin
        if (ifa.done === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_rxdataout", ifa.rxdataout, e.data);
                chk("a_stopbiterror", ifa.stopbiterror, e.serr);
                chk("a_parityerror", ifa.parityerror, e.perr);
                chk("a_done_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.done === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_rxdataout", ifb.rxdataout, e.data);
                chk("b_stopbiterror", ifb.stopbiterror, e.serr);
                chk("b_parityerror", ifb.parityerror, e.perr);
                chk("b_done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        ecnt[0] = 0;
        ecnt[1] = 0;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_a_busy", ifa.busy, 0);
        chk("rst_a_done", ifa.done, 0);
        chk("rst_a_data", ifa.rxdataout, 0);
        chk("rst_a_serr", ifa.stopbiterror, 0);
        chk("rst_a_perr", ifa.parityerror, 0);
        chk("rst_a_errcount", ifa.errcount, 0);
        chk("rst_b_busy", ifb.busy, 0);
        chk("rst_b_done", ifb.done, 0);
        chk("rst_b_data", ifb.rxdataout, 0);
        chk("rst_b_errcount", ifb.errcount, 0);
        reset = 1'b0;
        @(negedge clk);

        //    sel  data   p     mode poke clr  rst
        frame(0, 8'hA5, 1'b0, 0, 0, 0, 0);   // clean frame
        frame(0, 8'h3C, 1'b0, 1, 0, 0, 0);   // framing error, early abort
        frame(0, 8'h5A, 1'b0, 2, 0, 0, 0);   // line high only at sample point
        frame(0, 8'hC3, 1'b0, 0, 1, 0, 0);   // checkstop while busy / in REPORT
        frame(0, 8'h77, 1'b0, 0, 0, 0, 1);   // reset mid-frame
        frame(0, 8'h81, 1'b0, 0, 0, 0, 0);   // normal after reset
        repeat (256) frame(0, 8'hFF, 1'b0, 1, 0, 0, 0);  // saturate at 255
        frame(0, 8'h11, 1'b0, 1, 0, 1, 0);   // errclr beats increment

        frame(1, 8'h01, 1'b0, 0, 0, 0, 0);   // parity error, 2 stop bits
        frame(1, 8'h01, 1'b1, 0, 0, 0, 0);   // parity good
        frame(1, 8'hF0, 1'b0, 2, 0, 0, 0);   // both stop samples high only
        frame(1, 8'h0F, 1'b1, 1, 0, 0, 0);   // framing + parity error

        repeat (5) @(negedge clk);
        chk("a_missing_done", qa.size(), 0);
        chk("b_missing_done", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
